umi_req_split: RTL and testbench



---
 rtl/umi_req_split_pkg.sv | 33 +++
 rtl/umi_req_split_beat.sv | 34 +++
 rtl/umi_req_split.sv | 171 +++++++++++++++++
 tb/tb_umi_req_split.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_req_split_pkg.sv
// Shared UMI definitions for the request splitter: opcodes, command-word
// field positions, FSM state type and small opcode helpers.
package umi_req_split_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 5;
  localparam int SIZE_LSB = 5;
  localparam int SIZE_W   = 3;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 8;
  localparam int EOM_BIT  = 22;
  localparam int EOF_BIT  = 23;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  // Requests that are cut into narrower beats; everything else passes whole.
  function automatic logic is_split_op(input logic [OPC_W-1:0] opc);
    return (opc == UMI_REQ_READ) || (opc == UMI_REQ_WRITE) || (opc == UMI_REQ_POSTED);
  endfunction

  // Requests whose payload must fit in the input data bus.
  function automatic logic is_write_op(input logic [OPC_W-1:0] opc);
    return (opc == UMI_REQ_WRITE) || (opc == UMI_REQ_POSTED);
  endfunction

endpackage

// File: rtl/umi_req_split_beat.sv
// Per-beat calculator: from element size and words still to send, derives
// the word count of this beat, its LEN field, whether it is the last beat,
// and the byte increment to apply to both addresses afterwards.
module umi_req_split_beat #(
  parameter int AW  = 64,
  parameter int ODW = 64
) (
  input  logic [2:0]    size_i,
  input  logic [8:0]    rem_i,
  output logic [8:0]    n_o,
  output logic [7:0]    len_o,
  output logic          last_o,
  output logic [AW-1:0] incr_o
);

  localparam int BPB = ODW / 8;

  logic [8:0] wpb;

  // Beat size is the smaller of words remaining and words per output beat.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    wpb    = 9'(BPB >> size_i);
    n_o    = wpb;
    last_o = 1'b0;
    if (rem_i <= wpb) begin
      n_o    = rem_i;
      last_o = 1'b1;
    end
    len_o  = 8'(n_o - 9'd1);
    incr_o = AW'(n_o) << size_i;
  end

endmodule

// File: rtl/umi_req_split.sv
// UMI request splitter: accepts one wide request and replays it as a run of
// ODW-wide beats, rewriting LEN, addresses and EOM/EOF on each beat.
// Oversized requests are swallowed and flagged with a one-cycle pulse.
module umi_req_split
  import umi_req_split_pkg::*;
#(
  parameter int CW  = 32,
  parameter int AW  = 64,
  parameter int IDW = 256,
  parameter int ODW = 64
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic           umi_in_valid,
  input  logic [CW-1:0]  umi_in_cmd,
  input  logic [AW-1:0]  umi_in_dstaddr,
  input  logic [AW-1:0]  umi_in_srcaddr,
  input  logic [IDW-1:0] umi_in_data,
  output logic           umi_in_ready,
  output logic           umi_out_valid,
  output logic [CW-1:0]  umi_out_cmd,
  output logic [AW-1:0]  umi_out_dstaddr,
  output logic [AW-1:0]  umi_out_srcaddr,
  output logic [ODW-1:0] umi_out_data,
  input  logic           umi_out_ready,
  output logic           err_oversize
);

  split_state_e   state_q;
  logic [CW-1:0]  tmpl_cmd_q;   // command of the request being split
  logic [AW-1:0]  nxt_dst_q;    // destination of the following beat
  logic [AW-1:0]  nxt_src_q;    // source of the following beat
  logic [IDW-1:0] data_q;       // payload not yet emitted, beat 0 at LSBs
  logic [8:0]     rem_q;        // words left after the beat on the output
  logic           out_valid_q;
  logic [CW-1:0]  out_cmd_q;
  logic [AW-1:0]  out_dst_q;
  logic [AW-1:0]  out_src_q;
  logic [ODW-1:0] out_data_q;
  logic           err_q;

  logic [OPC_W-1:0]  in_opc;
  logic [SIZE_W-1:0] in_size;
  logic [8:0]        in_total;
  logic [31:0]       in_elem_bytes;
  logic [31:0]       in_req_bytes;
  logic              in_split;
  logic              in_oversize;
  logic              last_hs;
  logic              advance;
  logic              in_accept;

  assign in_opc        = umi_in_cmd[OPC_LSB +: OPC_W];
  assign in_size       = umi_in_cmd[SIZE_LSB +: SIZE_W];
  assign in_total      = {1'b0, umi_in_cmd[LEN_LSB +: LEN_W]} + 9'd1;
  assign in_elem_bytes = 32'd1 << in_size;
  assign in_req_bytes  = {23'd0, in_total} << in_size;
  assign in_split      = is_split_op(in_opc);
  assign in_oversize   = (in_elem_bytes > 32'(ODW / 8)) ||
                         (is_write_op(in_opc) && (in_req_bytes > 32'(IDW / 8)));

  // The output beat is always valid in SPLIT; rem_q == 0 marks the last one.
  assign last_hs      = (state_q == ST_SPLIT) && umi_out_ready && (rem_q == 9'd0);
  assign advance      = (state_q == ST_SPLIT) && umi_out_ready && (rem_q != 9'd0);
  assign umi_in_ready = (state_q == ST_IDLE) || last_hs;
  assign in_accept    = umi_in_valid && umi_in_ready;

  // One calculator serves both the first beat (from the input) and later beats.
  logic [2:0]    calc_size;
  logic [8:0]    calc_rem;
  logic [8:0]    beat_n;
  logic [7:0]    beat_len;
  logic          beat_last;
  logic [AW-1:0] beat_incr;

  assign calc_size = in_accept ? in_size : tmpl_cmd_q[SIZE_LSB +: SIZE_W];
  assign calc_rem  = in_accept ? in_total : rem_q;

  umi_req_split_beat #(
    .AW  (AW),
    .ODW (ODW)
  ) u_beat (
    .size_i (calc_size),
    .rem_i  (calc_rem),
    .n_o    (beat_n),
    .len_o  (beat_len),
    .last_o (beat_last),
    .incr_o (beat_incr)
  );

  logic [CW-1:0] base_cmd;
  logic [CW-1:0] beat_cmd;

  // Rewrite LEN and gate EOM/EOF so only the final beat carries them.
  always_comb begin
    base_cmd                      = in_accept ? umi_in_cmd : tmpl_cmd_q;
    beat_cmd                      = base_cmd;
    beat_cmd[LEN_LSB +: LEN_W]    = beat_len;
    beat_cmd[EOM_BIT]             = base_cmd[EOM_BIT] & beat_last;
    beat_cmd[EOF_BIT]             = base_cmd[EOF_BIT] & beat_last;
  end

  // Split FSM with registered outputs; beats only change on accept or handshake.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: the datapath registers are reset as well, since the outputs must read 0 in reset.
    if (!nreset) begin
      state_q     <= ST_IDLE;
      tmpl_cmd_q  <= '0;
      nxt_dst_q   <= '0;
      nxt_src_q   <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch reads pre-edge register values.
      err_q <= 1'b0;
      if (in_accept) begin
        if (!in_split) begin
          state_q     <= ST_SPLIT;
          rem_q       <= 9'd0;
          out_valid_q <= 1'b1;
          out_cmd_q   <= umi_in_cmd;
          out_dst_q   <= umi_in_dstaddr;
          out_src_q   <= umi_in_srcaddr;
          out_data_q  <= umi_in_data[ODW-1:0];
        end else if (in_oversize) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          err_q       <= 1'b1;
        end else begin
          state_q     <= ST_SPLIT;
          tmpl_cmd_q  <= umi_in_cmd;
          rem_q       <= in_total - beat_n;
          nxt_dst_q   <= umi_in_dstaddr + beat_incr;
          nxt_src_q   <= umi_in_srcaddr + beat_incr;
          data_q      <= umi_in_data >> ODW;
          out_valid_q <= 1'b1;
          out_cmd_q   <= beat_cmd;
          out_dst_q   <= umi_in_dstaddr;
          out_src_q   <= umi_in_srcaddr;
          out_data_q  <= umi_in_data[ODW-1:0];
        end
      end else if (last_hs) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
      end else if (advance) begin
        rem_q      <= rem_q - beat_n;
        nxt_dst_q  <= nxt_dst_q + beat_incr;
        nxt_src_q  <= nxt_src_q + beat_incr;
        data_q     <= data_q >> ODW;
        out_cmd_q  <= beat_cmd;
        out_dst_q  <= nxt_dst_q;
        out_src_q  <= nxt_src_q;
        out_data_q <= data_q[ODW-1:0];
      end
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dst_q;
  assign umi_out_srcaddr = out_src_q;
  assign umi_out_data    = out_data_q;
  assign err_oversize    = err_q;

endmodule

// File: tb/tb_umi_req_split.sv
// Self-checking bench for umi_req_split: directed cases plus random traffic,
// compared beat-by-beat against a word-offset reference model.
module tb_umi_req_split;

  logic         clk;
  logic         nreset;
  logic         umi_in_valid;
  logic [31:0]  umi_in_cmd;
  logic [63:0]  umi_in_dstaddr;
  logic [63:0]  umi_in_srcaddr;
  logic [255:0] umi_in_data;
  logic         umi_in_ready;
  logic         umi_out_valid;
  logic [31:0]  umi_out_cmd;
  logic [63:0]  umi_out_dstaddr;
  logic [63:0]  umi_out_srcaddr;
  logic [63:0]  umi_out_data;
  logic         umi_out_ready;
  logic         err_oversize;

  umi_req_split dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .err_oversize    (err_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  cmd;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] data;
  } req_t;

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
    bit          chk_data;
  } beat_t;

  req_t  req_q[$];
  beat_t exp_q[$];
  bit    err_pend;
  bit    rand_ready;
  int    stall_trig = -1;
  int    stall_left;
  int    beats_seen;
  int    errs_seen;
  int    compared;
  int    mismatched;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_cmd(input int opc, input int size, input int len);
    logic [31:0] c;
    c        = $urandom;
    c[4:0]   = 5'(opc);
    c[7:5]   = 3'(size);
    c[15:8]  = 8'(len);
    return c;
  endfunction

  // Reference: beat k covers words [done, done+n) of the request; addresses
  // are base + done*elem bytes and data is the k-th ODW slice of the input.
  function automatic void model(input req_t r);
    int    opc, size, total, elem, wpb, done, k, n;
    bit    last, wr;
    beat_t b;
    logic [255:0] sh;
    opc  = int'(r.cmd[4:0]);
    size = int'(r.cmd[7:5]);
    wr   = (opc == 3) || (opc == 5);
    if (!(opc == 1 || wr)) begin
      b = '{r.cmd, r.dst, r.src, r.data[63:0], 1'b1};
      exp_q.push_back(b);
      return;
    end
    total = int'(r.cmd[15:8]) + 1;
    elem  = 1 << size;
    if (elem > 8 || (wr && total * elem > 32)) begin
      err_pend = 1'b1;
      return;
    end
    wpb  = 8 / elem;
    done = 0;
    k    = 0;
    while (done < total) begin
      n          = (total - done < wpb) ? total - done : wpb;
      last       = (done + n == total);
      b.cmd      = r.cmd;
      b.cmd[15:8] = 8'(n - 1);
      b.cmd[22]  = r.cmd[22] & last;
      b.cmd[23]  = r.cmd[23] & last;
      b.dst      = r.dst + 64'(done * elem);
      b.src      = r.src + 64'(done * elem);
      sh         = r.data >> (64 * k);
      b.data     = sh[63:0];
      b.chk_data = (opc != 1);
      exp_q.push_back(b);
      done += n;
      k++;
    end
  endfunction

  task automatic push_req(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src);
    req_t r;
    r.cmd  = cmd;
    r.dst  = dst;
    r.src  = src;
    r.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_q.push_back(r);
  endtask

  // Cycle loop: sample at negedge, drive, then judge handshakes #1 later.
  task automatic run(input int budget, input bit expect_drain);
    int cyc = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0 || err_pend) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      check("out_valid", 64'(umi_out_valid), 64'(exp_q.size() > 0));
      check("err_oversize", 64'(err_oversize), 64'(err_pend));
      if (err_oversize) errs_seen++;
      err_pend = 1'b0;
      if (umi_out_valid && exp_q.size() > 0) begin
        check("out_cmd", 64'(umi_out_cmd), 64'(exp_q[0].cmd));
        check("out_dst", umi_out_dstaddr, exp_q[0].dst);
        check("out_src", umi_out_srcaddr, exp_q[0].src);
        if (exp_q[0].chk_data) check("out_data", umi_out_data, exp_q[0].data);
      end
      if (stall_left > 0) begin
        umi_out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        umi_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        umi_out_ready = 1'b1;
      end
      if (req_q.size() > 0) begin
        umi_in_valid   = 1'b1;
        umi_in_cmd     = req_q[0].cmd;
        umi_in_dstaddr = req_q[0].dst;
        umi_in_srcaddr = req_q[0].src;
        umi_in_data    = req_q[0].data;
      end else begin
        umi_in_valid = 1'b0;
      end
      #1;
      check("in_ready", 64'(umi_in_ready),
            64'(exp_q.size() == 0 || (exp_q.size() == 1 && umi_out_ready)));
      if (umi_out_valid && umi_out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        beats_seen++;
        if (beats_seen == stall_trig) begin
          stall_left = 3;
          stall_trig = -1;
        end
      end
      if (umi_in_valid && umi_in_ready) begin
        model(req_q[0]);
        void'(req_q.pop_front());
      end
    end
    if (expect_drain) check("drained", 64'(req_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    int b0, e0, opc, size, len;
    nreset         = 1'b0;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b0;
    #12;
    check("rst_out_valid", 64'(umi_out_valid), 64'd0);
    check("rst_err", 64'(err_oversize), 64'd0);
    check("rst_cmd", 64'(umi_out_cmd), 64'd0);
    check("rst_dst", umi_out_dstaddr, 64'd0);
    check("rst_data", umi_out_data, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("rst_in_ready", 64'(umi_in_ready), 64'd1);

    // Write, size 2, len 7: four beats of two words.
    b0 = beats_seen;
    push_req(mk_cmd(3, 2, 7) | 32'h00C0_0000, 64'h1000, 64'h2000);
    run(100, 1);
    check("wr_beats", 64'(beats_seen - b0), 64'd4);

    // Read, size 3, len 9: ten single-word beats.
    b0 = beats_seen;
    push_req(mk_cmd(1, 3, 9) | 32'h00C0_0000, 64'h0, 64'h8000);
    run(100, 1);
    check("rd_beats", 64'(beats_seen - b0), 64'd10);

    // Posted write, size 0, len 10: eight bytes then three.
    b0 = beats_seen;
    push_req(mk_cmd(5, 0, 10), 64'hFFFF_FFFF_FFFF_FFFC, 64'h40);
    run(100, 1);
    check("pw_beats", 64'(beats_seen - b0), 64'd2);

    // Atomic passes through as a single unchanged beat.
    b0 = beats_seen;
    push_req(mk_cmd(9, 2, 5), 64'h1234_5678, 64'h9ABC_DEF0);
    run(100, 1);
    check("atomic_beats", 64'(beats_seen - b0), 64'd1);

    // Oversize write (36B > 32B) and oversize read element (16B > 8B).
    b0 = beats_seen;
    e0 = errs_seen;
    push_req(mk_cmd(3, 2, 8), 64'h100, 64'h200);
    run(100, 1);
    push_req(mk_cmd(1, 4, 0), 64'h100, 64'h200);
    run(100, 1);
    check("ovs_errs", 64'(errs_seen - e0), 64'd2);
    check("ovs_beats", 64'(beats_seen - b0), 64'd0);

    // Largest read: 256 single-word beats.
    b0 = beats_seen;
    push_req(mk_cmd(1, 3, 255), 64'hFFFF_FFFF_FFFF_FF00, 64'h0);
    run(1000, 1);
    check("max_beats", 64'(beats_seen - b0), 64'd256);

    // Backpressure: three stalled cycles after the second beat.
    b0 = beats_seen;
    stall_trig = beats_seen + 2;
    push_req(mk_cmd(3, 0, 31), 64'h3000, 64'h4000);
    run(100, 1);
    check("bp_beats", 64'(beats_seen - b0), 64'd4);

    // Back-to-back writes; out_valid is checked every cycle, so a gap fails.
    b0 = beats_seen;
    push_req(mk_cmd(3, 2, 7), 64'h5000, 64'h6000);
    push_req(mk_cmd(5, 1, 15), 64'h7000, 64'h8000);
    run(100, 1);
    check("b2b_beats", 64'(beats_seen - b0), 64'd8);

    // Reset in the middle of a burst.
    push_req(mk_cmd(1, 3, 9), 64'h0, 64'h0);
    run(4, 0);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(umi_out_valid), 64'd0);
    check("mid_rst_cmd", 64'(umi_out_cmd), 64'd0);
    check("mid_rst_dst", umi_out_dstaddr, 64'd0);
    check("mid_rst_err", 64'(err_oversize), 64'd0);
    exp_q.delete();
    req_q.delete();
    err_pend      = 1'b0;
    umi_in_valid  = 1'b0;
    umi_out_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check("post_rst_ready", 64'(umi_in_ready), 64'd1);
    check("post_rst_valid", 64'(umi_out_valid), 64'd0);

    // Random traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0: opc = 1;
        1, 2: opc = 3;
        3: opc = 5;
        4: opc = 9;
        default: opc = int'($urandom_range(0, 31));
      endcase
      size = int'($urandom_range(0, 4));
      if (opc == 3 || opc == 5)
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, (32 >> size) - 1));
      else
        len = int'($urandom_range(0, 63));
      push_req(mk_cmd(opc, size, len), {$urandom, $urandom}, {$urandom, $urandom});
    end
    run(30000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
